// File: rtl/ysyx_2022040010_if_id_buf.sv
// IF/ID pipeline register with a one-deep instruction holding buffer.
// Keeps the SRAM read data across stalls, squashes wrong-path fetches and pre-decodes register indices and the immediate.
module ysyx_2022040010_if_id_buf #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               br_e,
    input  logic [128:0]       if_to_id_bus,
    input  logic [31:0]        isram_rdata,
    output logic               id_valid,
    output logic [63:0]        id_pc,
    output logic [63:0]        id_next_pc,
    output logic [31:0]        id_inst,
    output logic [4:0]         id_rs1,
    output logic [4:0]         id_rs2,
    output logic [4:0]         id_rd,
    output logic [63:0]        id_imm
);

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Sign-extended immediate for every base-ISA format; unknown opcodes yield zero.
    function automatic logic [63:0] imm_decode(input logic [31:0] inst);
        logic [63:0] imm;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b1110011:
                imm = {{52{inst[31]}}, inst[31:20]};
            7'b0100011:
                imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011:
                imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {{32{inst[31]}}, inst[31:12], 12'h000};
            7'b1101111:
                imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 64'd0;
        endcase
        return imm;
    endfunction

    logic        hold_s;
    logic        ce_s;
    logic [63:0] bus_pc_s;
    logic [63:0] bus_next_pc_s;
    logic        unused_stall_s;

    logic        valid_r;
    logic [63:0] pc_r;
    logic [63:0] next_pc_r;
    logic [31:0] inst_buf_r;
    buf_state_e  state_r;
    buf_state_e  state_nxt_s;
    logic        capture_s;
    logic        buf_full_s;
    logic [31:0] raw_inst_s;

    assign hold_s         = stall[0] | stall[1];
    assign unused_stall_s = ^stall[STALL_W-1:2];
    assign ce_s           = if_to_id_bus[128];
    assign bus_pc_s       = if_to_id_bus[127:64];
    assign bus_next_pc_s  = if_to_id_bus[63:0];

    // Slot registers: frozen on hold, bubble on branch redirect, otherwise follow fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            pc_r      <= 64'd0;
            next_pc_r <= 64'd0;
        end else if (hold_s) begin
            valid_r   <= valid_r;
            pc_r      <= pc_r;
            next_pc_r <= next_pc_r;
        end else begin
            valid_r   <= ce_s & ~br_e;
            pc_r      <= bus_pc_s;
            next_pc_r <= bus_next_pc_s;
        end
    end

    // Buffer FSM next state: capture only on the first hold cycle of a real instruction.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (hold_s && valid_r) begin
                    state_nxt_s = BUF_FULL;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (hold_s) begin
                    state_nxt_s = BUF_FULL;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            default: state_nxt_s = BUF_EMPTY;
        endcase
    end

    // Buffer state and captured instruction word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BUF_EMPTY;
            inst_buf_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                inst_buf_r <= isram_rdata;
            end else begin
                inst_buf_r <= inst_buf_r;
            end
        end
    end

    // Later hold cycles see the frozen fetch pc's data on the SRAM, so the buffer must win while full.
    always_comb begin
        buf_full_s = (state_r == BUF_FULL);
        raw_inst_s = buf_full_s ? inst_buf_r : isram_rdata;
        if (valid_r) begin
            id_inst = raw_inst_s;
        end else begin
            id_inst = NOP_INST;
        end
    end

    assign id_valid   = valid_r;
    assign id_pc      = pc_r;
    assign id_next_pc = next_pc_r;
    assign id_rs1     = id_inst[19:15];
    assign id_rs2     = id_inst[24:20];
    assign id_rd      = id_inst[11:7];
    assign id_imm     = imm_decode(id_inst);

endmodule

// File: doc/ysyx_2022040010_if_id_buf.md
# ysyx_2022040010_if_id_buf

Pipeline register and instruction holding buffer between the fetch stage and the decoder. It registers the fetch-stage bus and pairs it with the synchronous instruction SRAM read data. It captures that data on the first stall cycle, so the instruction is not lost while fetch is frozen. It drops wrong-path fetches on a branch and pre-decodes register indices and the sign-extended immediate for the decoder.

## Interface
Parameters:
- NOP_INST, 32'h0000_0013, instruction presented when the slot is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  `StallBus  pipeline stall vector; hold = stall[0] | stall[1] (exe stall or load stall).
- br_e  in  1  branch redirect taken this cycle (same signal the fetch stage consumes).
- if_to_id_bus  in  129  {ce[128], pc[127:64], next_pc[63:0]} from fetch.
- isram_rdata  in  32  SRAM read data for the address presented on the previous edge.
- id_valid  out  1  slot holds a real instruction.
- id_pc  out  64  pc of the slot instruction.
- id_next_pc  out  64  fetch's next_pc captured with it.
- id_inst  out  32  instruction word; NOP_INST when id_valid=0.
- id_rs1, id_rs2, id_rd  out  5 each  inst[19:15], [24:20], [11:7] of id_inst.
- id_imm  out  64  sign-extended immediate of id_inst.

## Operation
- Slot registers: r_valid, r_pc, r_next_pc.
  - hold=1: all slot registers keep their value.
  - hold=0 and br_e=1: r_valid<=0. Pc fields load normally, but the slot is a bubble.
  - otherwise: r_valid<=ce; r_pc<=pc; r_next_pc<=next_pc.
- br_e has no effect while hold=1. Stall wins, matching fetch, which also freezes.
- Buffer FSM (EMPTY/FULL), registers inst_buf[31:0] and buf_full:
  - EMPTY -> FULL when hold=1 and r_valid=1: inst_buf<=isram_rdata.
  - FULL stays FULL while hold=1; inst_buf is not overwritten.
  - any state -> EMPTY when hold=0.
- Instruction select: raw = buf_full ? inst_buf : isram_rdata; id_inst = r_valid ? raw : NOP_INST.
- Immediate by id_inst[6:0]:
  - I-type, opcodes 0010011, 0000011, 1100111, 0011011, 1110011: sext(inst[31:20]).
  - S-type, 0100011: sext({inst[31:25],inst[11:7]}).
  - B-type, 1100011: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U-type, 0110111, 0010111: sext({inst[31:12],12'b0}).
  - J-type, 1101111: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - any other opcode: 0.
  - All sign extension is from the instruction's bit 31 to 64 bits.
- Outputs id_pc, id_next_pc, id_valid are driven directly from the slot registers. Register fields and immediate are combinational from id_inst.

## Timing
- Reset values: r_valid=0, r_pc=0, r_next_pc=0, buf_full=0, inst_buf=0. Hence id_valid=0, id_inst=NOP_INST, id_rs1=0, id_rs2=0, id_rd=0, id_imm=0.
- Latency: bus sampled at edge N appears on id_* during cycle N+1. isram_rdata for that pc is valid during cycle N+1 only.
- First hold cycle: the SRAM still outputs the slot's instruction, so it is captured at the end of that cycle. Later hold cycles: the SRAM output belongs to the frozen fetch pc and is ignored via the buffer.
- Release cycle (first hold=0): the buffer still drives id_inst, the slot advances at that edge, and the buffer clears at the same edge.
- Hold while r_valid=0: no capture, and the NOP stays.
- Reset asserted mid-hold: the next cycle has buf_full=0 and id_valid=0 regardless of stall.
- ce=0 (first cycle after reset): a bubble enters the slot.

## Test plan
- Reset, then release with stall=0. Drive pc=0x8000_0000 ce=1 -> next cycle id_valid=1, id_pc=0x8000_0000. With isram_rdata=0x0010_0093, id_inst=0x0010_0093, rd=1, id_imm=1.
- Slot holds 0x8000_0004 with rdata 0x0000_0013. Assert stall[1] for 3 cycles with rdata changing to 0xDEAD_BEEF after the first cycle -> id_inst stays 0x0000_0013 for all 3 cycles plus the release cycle, and id_pc is constant.
- br_e=1, stall=0, bus pc=0x8000_0010 -> next cycle id_valid=0, id_inst=0x0000_0013. Repeat with stall[0]=1 -> the slot is unchanged.
- Immediates:
  - 0xFE00_0EE3 (B-type, beq x0,x0,-4) -> id_imm=0xFFFF_FFFF_FFFF_FFFC.
  - 0x8000_02B7 (LUI) -> id_imm=0xFFFF_FFFF_8000_0000.
  - 0x0040_006F (JAL) -> id_imm=4.
  - 0xFE11_3C23 (S-type) -> id_imm=0xFFFF_FFFF_FFFF_FFF8.
- Assert rst during a 2-cycle stall with the buffer full -> the next cycle has id_valid=0, id_inst=NOP_INST, and the buffer is empty. After release, new rdata passes straight through.
- Stall while the slot is a bubble (ce=0) -> no capture. After release, the first valid instruction comes from isram_rdata, not stale buffer data.
